// File: rtl/uart_tx.sv
// 8-bit UART transmitter (8N1/8N2, LSB first, idle-high) with valid/ready byte input.
// Define UART_TX_PARITY_EN to add a parity bit (even/odd chosen by PARITY_ODD).
module uart_tx #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned IDX_W        = 3;

   // Reject configurations the bit timing and frame format cannot support
   if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1) begin : g_cfg_err
      $error("uart_tx: illegal CLK_HZ/BAUD, STOP_BITS or PARITY_ODD");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [DATA_W-1:0]         shift_q, shift_d;
   logic                      tx_d, ready_d, busy_d;
   logic                      bit_end;

   assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

   // Next state; idx counts data bits in DATA and stop bits in STOP
   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      shift_d = shift_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (in_valid) begin
               shift_d = in_data;
               idx_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               idx_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_W'(DATA_W - 1)) begin
                  idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               idx_d   = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from the next state so they change on the same edge as the state
   always_comb begin
      tx_d    = 1'b1;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      case (state_d)
         S_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_d = (^shift_d) ^ 1'(PARITY_ODD);
`endif
         S_STOP:   tx_d = 1'b1;
         default: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx       <= 1'b1;
         in_ready <= 1'b1;
         busy     <= 1'b0;
      end else begin
         tx       <= tx_d;
         in_ready <= ready_d;
         busy     <= busy_d;
      end
   end

endmodule
